// File: rtl/kword_enum.sv
// Enumerates every WIDTH-bit word with exactly K ones in ascending order,
// one word per valid/ready handshake, using the Gosper successor.
module kword_enum #(
  parameter int WIDTH = 8,
  parameter int KW    = 4,
  parameter int IDXW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KW-1:0]    k,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] data_q;
  logic [IDXW-1:0]  idx_q;
  logic             busy_q, valid_q, last_q, done_q, err_q;

  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] top_mask;
  logic [WIDTH:0]   cur_w, c_w, r_w, succ_w;
  int               tz;
  logic             last_d;
  logic             start_ok;

  // First word (low k bits set) from the live k; final word (top k_q bits) from the latched k.
  always_comb begin
    first_word = '0;
    top_mask   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      first_word[i] = (i < int'(k));
      top_mask[i]   = (i >= WIDTH - int'(k_q));
    end
  end

  // Gosper successor, one bit wider than the word so the carry out of r is kept.
  always_comb begin
    cur_w = {1'b0, data_q};
    c_w   = cur_w & (-cur_w);
    r_w   = cur_w + c_w;
    tz    = 0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (c_w[i]) tz = i;
    end
    succ_w = r_w | (((r_w ^ cur_w) >> 2) >> tz);
    last_d = (succ_w == {1'b0, top_mask});
  end

  assign start_ok = (k <= KW'(WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              state_q <= S_RUN;
              k_q     <= k;
              data_q  <= first_word;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              // k=0 and k=WIDTH each have exactly one word.
              last_q  <= (k == '0) || (k == KW'(WIDTH));
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (valid_q && out_ready) begin
            if (last_q) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q <= succ_w[WIDTH-1:0];
              idx_q  <= idx_q + IDXW'(1);
              last_q <= last_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_kword_enum.sv
// Directed bench for kword_enum: compares the stream against a brute-force
// list of all words with the requested popcount.
module tb_kword_enum;

  localparam int WIDTH = 8;
  localparam int KW    = 4;
  localparam int IDXW  = 8;
  localparam int BUDGET = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [KW-1:0]    k;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             done;
  logic             err;

  int n_chk = 0;
  int n_bad = 0;

  kword_enum #(.WIDTH(WIDTH), .KW(KW), .IDXW(IDXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k         (k),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run for kk; ready asserted pct% of cycles; start re-pulsed with k=5
  // at cycle inj; returns early (mid-run) after abort_n transfers.
  task automatic run_k(input int kk, input int pct, input int inj, input int abort_n);
    logic [WIDTH-1:0] exp_q[$];
    int n;
    int cyc;
    bit rdy;
    exp_q = {};
    for (int v = 0; v < (1 << WIDTH); v++) begin
      if ($countones(v[WIDTH-1:0]) == kk) exp_q.push_back(v[WIDTH-1:0]);
    end
    start = 1'b1;
    k = KW'(kk);
    tick();
    start = 1'b0;
    k = KW'(kk + 3);
    chk("busy_run", busy, 1);
    n = 0;
    cyc = 0;
    while (n < exp_q.size() && cyc < BUDGET) begin
      chk("valid", out_valid, 1);
      chk("data", out_data, exp_q[n]);
      chk("idx", out_idx, n);
      chk("last", out_last, (n == exp_q.size() - 1));
      chk("popcnt", $countones(out_data), kk);
      chk("done_mid", done, 0);
      if (cyc == inj) begin
        start = 1'b1;
        k = KW'(5);
      end else begin
        start = 1'b0;
      end
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      tick();
      cyc++;
      if (rdy) n++;
      if (abort_n >= 0 && n == abort_n) begin
        out_ready = 1'b0;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("budget", (cyc < BUDGET), 1);
    chk("done_pulse", done, 1);
    chk("valid_done", out_valid, 0);
    chk("busy_done", busy, 1);
    tick();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    k = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Sweep every legal k with ready held high.
    for (int kk = 0; kk <= WIDTH; kk++) run_k(kk, 100, -1, -1);

    // Illegal k: one-cycle err, nothing else moves.
    start = 1'b1;
    k = KW'(9);
    tick();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_valid", out_valid, 0);
    chk("err_busy", busy, 0);
    chk("err_done", done, 0);
    tick();
    chk("err_clear", err, 0);
    chk("err_valid2", out_valid, 0);
    run_k(1, 100, -1, -1);

    // Backpressure.
    run_k(3, 50, -1, -1);

    // Start while running must be ignored.
    run_k(2, 100, 10, -1);

    // Reset mid-run after the 5th transfer.
    run_k(3, 100, -1, 5);
    chk("pre_rst_data", out_data, 8'h15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    tick();
    chk("mid_rst_done2", done, 0);
    run_k(2, 100, -1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/kword_enum.md
Name: kword_enum

Overview:
- Inverse of the team's popcount block. Given a target count K, it emits every WIDTH-bit word with exactly K ones, one word per handshake, in strictly ascending numeric order.
- Feeds test-vector generation and combinatorial-search logic next to the popcount datapath.
- Output is a valid/ready stream with last, index and done/error status.

Parameters:
WIDTH, 8, word width in bits (2..16)
KW, 4, width of k input; must satisfy 2^KW > WIDTH
IDXW, 8, width of out_idx; must hold C(WIDTH, WIDTH/2)-1 (70-1 for WIDTH=8)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request enumeration; sampled only in IDLE
k  input  KW  target ones count; sampled with start
busy  output  1  high while not IDLE
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  consumer accepts current word
out_data  output  WIDTH  current word, popcount == k
out_idx  output  IDXW  0-based ordinal of current word
out_last  output  1  current word is the final one
done  output  1  one-cycle pulse after last word accepted
err  output  1  one-cycle pulse on rejected start (k > WIDTH)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, out_valid, out_last, done, err = 0; out_data, out_idx = 0. Reset has priority over every other input, including mid-run; a partially delivered sequence is abandoned with no done pulse.
- States:
  - IDLE: waiting for start.
  - RUN: presenting words.
  - DONE: single cycle that pulses done, then returns to IDLE.
- IDLE, start=1, k<=WIDTH: next cycle state=RUN, out_valid=1, out_data=(1<<k)-1, out_idx=0, busy=1. First word therefore appears 1 cycle after start.
- IDLE, start=1, k>WIDTH: err=1 for exactly the next cycle; state stays IDLE; out_valid stays 0.
- IDLE, start=0: done and err are 0.
- start in RUN or DONE is ignored, and so is k. No queuing.
- Latch k at start; later changes to k have no effect.
- RUN handshake:
  - Transfer occurs on a cycle with out_valid && out_ready.
  - While out_valid && !out_ready: out_data, out_idx and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- RUN, transfer, out_last=0: next cycle out_data = next larger word with the same popcount (Gosper successor); out_idx += 1. Zero-bubble, so back-to-back transfers at 1 word/cycle when out_ready is held high.
  - Successor: c = cur & -cur; r = cur + c; next = r | (((r ^ cur) >> 2) >> tz(c)).
  - tz = trailing-zero count.
  - Computed at WIDTH+1 bits internally so the carry is not lost.
  - Must be single-cycle combinational from registered cur; no divider.
- out_last=1 when out_data == ((1<<k)-1) << (WIDTH-k), i.e. the top K bits are set. This includes the single-word cases:
  - k=0: word 0x00.
  - k=WIDTH: all ones.
- RUN, transfer, out_last=1: next cycle state=DONE, out_valid=0, out_last=0, done=1. The cycle after that: IDLE, busy=0, done=0.
- Total words per run = C(WIDTH,k). Final out_idx = C(WIDTH,k)-1.
- Registered outputs only; no combinational path from out_ready to out_valid or out_data.

Test Plan:
- k=2, out_ready=1, start pulsed one cycle:
  - Words 0x03,0x05,0x06,0x09,0x0A,0x0C,0x11,..., last 0xC0.
  - 28 words, out_idx 0..27, out_last only on 0xC0.
  - done pulses once, 1 cycle after the 0xC0 transfer.
  - Cross-check every word against the popcount block == 2 and strictly increasing.
- Sweep k=0..8, ready=1:
  - k=0 gives a single 0x00 with out_last=1.
  - k=8 gives a single 0xFF with out_last=1.
  - k=4 gives 70 words, first 0x0F, last 0xF0.
- k=9 with start: err=1 exactly one cycle after; out_valid, busy and done stay 0. A following start with k=1 works normally (0x01..0x80, 8 words).
- Backpressure, k=3, out_ready random ~50%:
  - out_data/out_idx stable on every stalled cycle.
  - Exactly 56 transfers with no duplicates or gaps.
  - Last word 0xE0.
- k=3, reset asserted after the 5th transfer (word 0x13):
  - Next cycle all outputs 0, state IDLE, no done pulse.
  - A new start with k=2 restarts at 0x03, out_idx=0.
- start with k=5 pulsed while in RUN for k=2: ignored. The stream continues the k=2 sequence unchanged to 0xC0.
